// File: rtl/red_pitaya_decimator_block_pkg.sv
// Shared definitions for the decimating boxcar averager.
//   - default sample width and largest log2 window length
//   - IDLE/ACCUM state encoding
//   - clamp helper for the requested log2 window length
package red_pitaya_decimator_block_pkg;

  localparam int DEF_SIGNALBITS = 14;
  localparam int DEF_LOG2MAX    = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Requests above the supported maximum are clamped rather than wrapped.
  function automatic logic [3:0] clamp_log2(input logic [3:0] req,
                                            input logic [3:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/red_pitaya_decimator_block_minmax_tracker.sv
// Running minimum/maximum of the samples in the current window.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   seed          : dat_i is sample 0 of a window (restarts the extremes)
//   update        : window is running; when low the stored extremes clear
//   dat_i         : signed sample of this cycle
//   min_o, max_o  : extremes of the window including this cycle's dat_i
//                   (combinational, so the caller can latch the final
//                   values on the completing cycle without a bubble)
module red_pitaya_minmax_tracker
  import red_pitaya_decimator_block_pkg::*;
#(
  parameter int W = DEF_SIGNALBITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                seed,
  input  logic                update,
  input  logic signed [W-1:0] dat_i,
  output logic signed [W-1:0] min_o,
  output logic signed [W-1:0] max_o
);

  logic signed [W-1:0] min_q;
  logic signed [W-1:0] max_q;

  always_comb begin
    min_o = min_q;
    max_o = max_q;
    if (seed) begin
      min_o = dat_i;
      max_o = dat_i;
    end else begin
      if (dat_i < min_q) min_o = dat_i;
      if (dat_i > max_q) max_o = dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      min_q <= '0;
      max_q <= '0;
    end else if (update) begin
      min_q <= min_o;
      max_q <= max_o;
    end else begin
      min_q <= '0;
      max_q <= '0;
    end
  end

endmodule

// File: rtl/red_pitaya_decimator_block.sv
// Decimating boxcar averager behind the filter block. Accumulates windows
// of 2^d samples and emits mean (floored), minimum and maximum together
// with a one-cycle valid strobe, one cycle after the window's last sample.
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   enable_i       : run (1) / idle (0); idle discards the open window
//   sync_i         : restart the window on this sample
//   set_decimation : log2 window length, clamped to LOG2MAX, sampled at
//                    each window start only
//   dat_i          : signed input sample, one per cycle
//   dat_o          : signed window mean (arithmetic shift, floors to -inf)
//   min_o, max_o   : signed window extremes
//   valid_o        : one-cycle strobe, outputs update with it
//   state_o        : current FSM state
//
// Handshake: there is no back-pressure. A sample is consumed on every
// clk_i edge where enable_i is high; valid_o is a pure strobe, asserted
// for exactly one cycle per completed window, and the data outputs hold
// their value until the next strobe.
module red_pitaya_decimator_block
  import red_pitaya_decimator_block_pkg::*;
#(
  parameter int SIGNALBITS = DEF_SIGNALBITS,
  parameter int LOG2MAX    = DEF_LOG2MAX
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         enable_i,
  input  logic                         sync_i,
  input  logic [3:0]                   set_decimation,
  input  logic signed [SIGNALBITS-1:0] dat_i,
  output logic signed [SIGNALBITS-1:0] dat_o,
  output logic signed [SIGNALBITS-1:0] min_o,
  output logic signed [SIGNALBITS-1:0] max_o,
  output logic                         valid_o,
  output state_t                       state_o
);

  localparam int         ACC_W = SIGNALBITS + LOG2MAX;
  localparam logic [3:0] D_MAX = 4'(LOG2MAX);

  state_t                    state;
  state_t                    state_next;
  logic [LOG2MAX-1:0]        cnt;
  logic [3:0]                d_active;
  logic signed [ACC_W-1:0]   acc;

  logic                      run;
  logic                      start;
  logic                      last;
  logic [3:0]                d_eff;
  logic [LOG2MAX-1:0]        cnt_eff;
  logic [LOG2MAX-1:0]        cnt_last;
  logic signed [ACC_W-1:0]   sum;
  logic signed [SIGNALBITS-1:0] trk_min;
  logic signed [SIGNALBITS-1:0] trk_max;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next state: enable_i acts on the edge where it is sampled.
  always_comb begin
    state_next = enable_i ? ST_ACCUM : ST_IDLE;
  end

  // Datapath controls. The window seen on this edge is the one the sample
  // belongs to: a start (first enabled cycle, counter wrap or sync) resets
  // the count/accumulator view and picks up a fresh window length, so a
  // sync on the would-be last sample never produces a strobe.
  always_comb begin
    run      = (state_next == ST_ACCUM);
    start    = run && (sync_i || (state == ST_IDLE) || (cnt == '0));
    d_eff    = start ? clamp_log2(set_decimation, D_MAX) : d_active;
    cnt_eff  = start ? '0 : cnt;
    cnt_last = LOG2MAX'((1 << d_eff) - 1);
    last     = run && (cnt_eff == cnt_last);
    sum      = (start ? '0 : acc)
             + {{LOG2MAX{dat_i[SIGNALBITS-1]}}, dat_i};
  end

  assign state_o = state;

  red_pitaya_minmax_tracker #(
    .W (SIGNALBITS)
  ) u_minmax (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .seed   (start),
    .update (run),
    .dat_i  (dat_i),
    .min_o  (trk_min),
    .max_o  (trk_max)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt      <= '0;
      acc      <= '0;
      d_active <= '0;
      dat_o    <= '0;
      min_o    <= '0;
      max_o    <= '0;
      valid_o  <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
    end else begin
      if (start) d_active <= d_eff;
      valid_o <= last;
      if (last) begin
        cnt   <= '0;
        acc   <= '0;
        // Accumulator is wide enough for 2^LOG2MAX full-scale samples,
        // so the shifted mean always fits back into SIGNALBITS.
        dat_o <= SIGNALBITS'(sum >>> d_eff);
        min_o <= trk_min;
        max_o <= trk_max;
      end else begin
        cnt <= cnt_eff + 1'b1;
        acc <= sum;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_decimator_block.sv
module tb_red_pitaya_decimator_block;
  import red_pitaya_decimator_block_pkg::*;

  localparam int SB  = 14;
  localparam int LMX = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  logic                 en;
  logic                 sync;
  logic [3:0]           setd;
  logic signed [SB-1:0] din;
  logic signed [SB-1:0] dat_o;
  logic signed [SB-1:0] min_o;
  logic signed [SB-1:0] max_o;
  logic                 valid_o;
  state_t               state_o;

  red_pitaya_decimator_block #(
    .SIGNALBITS (SB),
    .LOG2MAX    (LMX)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .enable_i       (en),
    .sync_i         (sync),
    .set_decimation (setd),
    .dat_i          (din),
    .dat_o          (dat_o),
    .min_o          (min_o),
    .max_o          (max_o),
    .valid_o        (valid_o),
    .state_o        (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the open window is a list of samples; a window is
  // complete when the list holds 2^d samples.
  int win[$];
  int d_act     = 0;
  int exp_dat   = 0;
  int exp_min   = 0;
  int exp_max   = 0;
  int exp_valid = 0;
  int exp_state = 0;

  function automatic int floor_div(int s, int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_edge();
    int sum;
    int mn;
    int mx;
    exp_state = en ? 1 : 0;
    if (!en) begin
      win.delete();
      exp_valid = 0;
    end else begin
      if (sync || win.size() == 0) begin
        win.delete();
        d_act = (int'(setd) > LMX) ? LMX : int'(setd);
      end
      win.push_back(int'(din));
      if (win.size() == (1 << d_act)) begin
        sum = 0;
        mn  = win[0];
        mx  = win[0];
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        exp_dat   = floor_div(sum, 1 << d_act);
        exp_min   = mn;
        exp_max   = mx;
        exp_valid = 1;
        win.delete();
      end else begin
        exp_valid = 0;
      end
    end
  endtask

  task automatic model_reset();
    win.delete();
    d_act     = 0;
    exp_dat   = 0;
    exp_min   = 0;
    exp_max   = 0;
    exp_valid = 0;
    exp_state = 0;
  endtask

  // Driver: one clock, model follows the DUT edge, outputs compared at the
  // falling edge. Inputs are only ever changed at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rstn_i) model_edge();
    @(negedge clk);
    check("valid", valid_o, exp_valid);
    check("dat",   dat_o,   exp_dat);
    check("min",   min_o,   exp_min);
    check("max",   max_o,   exp_max);
    check("state", (state_o == ST_ACCUM), exp_state);
    if (valid_o) n_valid++;
  endtask

  task automatic feed(input int v);
    din = SB'(v);
    step();
  endtask

  task automatic go_idle();
    en   = 1'b0;
    sync = 1'b0;
    step();
  endtask

  initial begin
    rstn_i = 1'b0;
    en     = 1'b0;
    sync   = 1'b0;
    setd   = 4'd0;
    din    = '0;
    model_reset();
    #12;
    check("rst_dat",   dat_o,   0);
    check("rst_min",   min_o,   0);
    check("rst_max",   max_o,   0);
    check("rst_valid", valid_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    step();
    step();

    // d=2: 4,8,-4,0 -> mean 2, min -4, max 8
    setd = 4'd2;
    en   = 1'b1;
    feed(4); feed(8); feed(-4);
    check("tp1_open", valid_o, 0);
    feed(0);
    check("tp1_mean", dat_o, 2);
    check("tp1_min",  min_o, -4);
    check("tp1_max",  max_o, 8);
    check("tp1_valid", valid_o, 1);
    n_valid = 0;
    repeat (8) feed($urandom_range(0, 16383) - 8192);
    check("tp1_period", n_valid, 2);

    // d=1: -3,0 -> floor(-1.5) = -2
    go_idle();
    setd = 4'd1;
    en   = 1'b1;
    feed(-3); feed(0);
    check("tp2_mean", dat_o, -2);
    check("tp2_min",  min_o, -3);
    check("tp2_max",  max_o, 0);

    // d=0: every sample is a window
    go_idle();
    setd = 4'd0;
    en   = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 10; i++) feed(i);
    check("tp3_all_valid", n_valid, 10);
    check("tp3_last", dat_o, 9);

    // d=3, shrink to 1 mid-window: window still 8 long
    go_idle();
    setd = 4'd3;
    en   = 1'b1;
    repeat (3) feed($urandom_range(0, 16383) - 8192);
    setd = 4'd1;
    repeat (4) feed($urandom_range(0, 16383) - 8192);
    check("tp4_open", valid_o, 0);
    feed($urandom_range(0, 16383) - 8192);
    check("tp4_done", valid_o, 1);
    n_valid = 0;
    repeat (6) feed($urandom_range(0, 16383) - 8192);
    check("tp4_period", n_valid, 3);

    // d=2, sync on the 4th sample suppresses the strobe
    go_idle();
    setd = 4'd2;
    en   = 1'b1;
    feed(100); feed(200); feed(300);
    sync = 1'b1;
    feed(-40);
    sync = 1'b0;
    check("tp5_nostrobe", valid_o, 0);
    feed(-20); feed(10);
    check("tp5_open", valid_o, 0);
    feed(50);
    check("tp5_valid", valid_o, 1);
    check("tp5_mean", dat_o, 0);
    check("tp5_min",  min_o, -40);
    check("tp5_max",  max_o, 50);

    // d=4, asynchronous reset mid-window
    go_idle();
    setd = 4'd4;
    en   = 1'b1;
    repeat (5) feed($urandom_range(0, 16383) - 8192);
    #2 rstn_i = 1'b0;
    model_reset();
    #1;
    check("arst_dat",   dat_o,   0);
    check("arst_min",   min_o,   0);
    check("arst_max",   max_o,   0);
    check("arst_valid", valid_o, 0);
    @(negedge clk);
    check("arst_hold", valid_o, 0);
    rstn_i = 1'b1;
    n_valid = 0;
    repeat (15) feed($urandom_range(0, 16383) - 8192);
    check("arst_no_early", n_valid, 0);
    feed($urandom_range(0, 16383) - 8192);
    check("arst_first", valid_o, 1);

    // clamp: 15 -> 1024-sample window, full-scale constants
    go_idle();
    setd = 4'd15;
    en   = 1'b1;
    n_valid = 0;
    repeat (1023) feed(8191);
    check("big_open", n_valid, 0);
    feed(8191);
    check("big_valid", valid_o, 1);
    check("big_pos", dat_o, 8191);
    repeat (1024) feed(-8192);
    check("big_neg", dat_o, -8192);

    // randomized traffic
    go_idle();
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 9) == 0) setd = 4'($urandom_range(7, 15));
        else                           setd = 4'($urandom_range(0, 5));
      end
      feed($urandom_range(0, 16383) - 8192);
    end
    en   = 1'b0;
    sync = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
